// File: rtl/ins_cache_ctrl_if.sv
// Fetch-side and DDR-fill-side handshake bundle for the instruction cache controller.
// The slave modport belongs to the cache; master is the requester/DDR environment.
interface ins_cache_ctrl_if #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int ISA_WIDTH      = 30
);
    logic                      ins_req;
    logic [DDR_ADDR_WIDTH-1:0] ins_addr;
    logic                      flush;
    logic                      ins_valid;
    logic [ISA_WIDTH-1:0]      ins_data;
    logic                      ddr_rd_req;
    logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr;
    logic                      ddr_rd_ack;
    logic                      ddr_rd_data_valid;
    logic [ISA_WIDTH-1:0]      ddr_rd_data;

    modport slave (
        input  ins_req, ins_addr, flush, ddr_rd_ack, ddr_rd_data_valid, ddr_rd_data,
        output ins_valid, ins_data, ddr_rd_req, ddr_rd_addr
    );

    modport master (
        output ins_req, ins_addr, flush, ddr_rd_ack, ddr_rd_data_valid, ddr_rd_data,
        input  ins_valid, ins_data, ddr_rd_req, ddr_rd_addr
    );
endinterface

// File: rtl/ins_cache_ctrl.sv
// Single-window instruction cache: a miss refills ISA_DEPTH consecutive words from DDR,
// hits are served from the window, which may wrap through address 0.
module ins_cache_ctrl #(
    parameter int ISA_DEPTH      = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int ISA_WIDTH      = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    ins_cache_ctrl_if.slave      bus,
    output logic [2:0]           st_cur,
    output logic [15:0]          miss_cnt
);
    localparam int IDX_W = $clog2(ISA_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd1,
        LOAD_REQ  = 3'd2,
        LOAD_DATA = 3'd3,
        SEND      = 3'd4
    } state_t;

    state_t                    state_r;
    logic [ISA_WIDTH-1:0]      mem_r [ISA_DEPTH];
    logic [DDR_ADDR_WIDTH-1:0] base_r;
    logic [DDR_ADDR_WIDTH-1:0] req_addr_r;
    logic [IDX_W-1:0]          fill_cnt_r;
    logic                      win_valid_r;
    logic                      flush_pend_r;
    logic [15:0]               miss_cnt_r;
    logic                      ins_valid_r;
    logic [ISA_WIDTH-1:0]      ins_data_r;
    logic                      ddr_rd_req_r;
    logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr_r;

    logic [DDR_ADDR_WIDTH-1:0] req_off_s;
    logic [IDX_W-1:0]          fill_idx_s;
    logic                      hit_s;
    logic                      last_beat_s;
    logic [ISA_WIDTH-1:0]      hit_data_s;
    logic [ISA_WIDTH-1:0]      fill_data_s;

    function automatic logic [DDR_ADDR_WIDTH-1:0] calc_off(
        input logic [DDR_ADDR_WIDTH-1:0] addr,
        input logic [DDR_ADDR_WIDTH-1:0] base
    );
        return addr - base;
    endfunction

    // Hit detection and read-data selection for both the hit and fill-completion paths.
    always_comb begin
        req_off_s   = calc_off(bus.ins_addr, base_r);
        fill_idx_s  = IDX_W'(calc_off(req_addr_r, base_r));
        hit_s       = win_valid_r && (req_off_s[DDR_ADDR_WIDTH-1:IDX_W] == '0) && !bus.flush;
        last_beat_s = (fill_cnt_r == IDX_W'(ISA_DEPTH - 1));
        hit_data_s  = mem_r[req_off_s[IDX_W-1:0]];
        // The word being written on the final beat is not yet in the array.
        fill_data_s = (fill_idx_s == fill_cnt_r) ? bus.ddr_rd_data : mem_r[fill_idx_s];
    end

    // Window storage written by fill beats; contents are not reset.
    always_ff @(posedge clk) begin
        if (state_r == LOAD_DATA && bus.ddr_rd_data_valid) begin
            mem_r[fill_cnt_r] <= bus.ddr_rd_data;
        end
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            base_r        <= '0;
            req_addr_r    <= '0;
            fill_cnt_r    <= '0;
            win_valid_r   <= 1'b0;
            flush_pend_r  <= 1'b0;
            miss_cnt_r    <= 16'd0;
            ins_valid_r   <= 1'b0;
            ins_data_r    <= '0;
            ddr_rd_req_r  <= 1'b0;
            ddr_rd_addr_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    ins_valid_r <= 1'b0;
                    ins_data_r  <= '0;
                    if (bus.flush) begin
                        win_valid_r <= 1'b0;
                    end
                    if (bus.ins_req) begin
                        req_addr_r <= bus.ins_addr;
                        if (hit_s) begin
                            state_r     <= SEND;
                            ins_valid_r <= 1'b1;
                            ins_data_r  <= hit_data_s;
                        end else begin
                            state_r       <= LOAD_REQ;
                            ddr_rd_req_r  <= 1'b1;
                            ddr_rd_addr_r <= bus.ins_addr;
                            if (miss_cnt_r != 16'hFFFF) begin
                                miss_cnt_r <= miss_cnt_r + 16'd1;
                            end
                        end
                    end
                end
                LOAD_REQ: begin
                    if (bus.flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (bus.ddr_rd_ack) begin
                        ddr_rd_req_r <= 1'b0;
                        base_r       <= req_addr_r;
                        win_valid_r  <= 1'b0;
                        fill_cnt_r   <= '0;
                        state_r      <= LOAD_DATA;
                    end
                end
                LOAD_DATA: begin
                    if (bus.flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (bus.ddr_rd_data_valid) begin
                        fill_cnt_r <= fill_cnt_r + IDX_W'(1);
                        if (last_beat_s) begin
                            // A flush arriving with the last beat still keeps the window invalid.
                            win_valid_r  <= !(flush_pend_r || bus.flush);
                            flush_pend_r <= 1'b0;
                            state_r      <= SEND;
                            ins_valid_r  <= 1'b1;
                            ins_data_r   <= fill_data_s;
                        end
                    end
                end
                SEND: begin
                    ins_valid_r <= 1'b0;
                    ins_data_r  <= '0;
                    state_r     <= IDLE;
                    if (bus.flush) begin
                        win_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    ins_valid_r  <= 1'b0;
                    ins_data_r   <= '0;
                    ddr_rd_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ins_valid   = ins_valid_r;
    assign bus.ins_data    = ins_data_r;
    assign bus.ddr_rd_req  = ddr_rd_req_r;
    assign bus.ddr_rd_addr = ddr_rd_addr_r;
    assign st_cur          = state_r;
    assign miss_cnt        = miss_cnt_r;
endmodule

// File: tb/tb_ins_cache_ctrl.sv
// Randomized self-checking bench for ins_cache_ctrl with a window-level reference model.
module tb_ins_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  st_cur;
    logic [15:0] miss_cnt;

    int checks = 0;
    int passed = 0;

    // reference model: one window of four words
    logic [29:0] mem_m [4];
    logic [7:0]  base_m  = 8'd0;
    bit          valid_m = 1'b0;
    logic [15:0] miss_m  = 16'd0;

    ins_cache_ctrl_if #(.DDR_ADDR_WIDTH(8), .ISA_WIDTH(30)) bus ();

    ins_cache_ctrl #(.ISA_DEPTH(4), .DDR_ADDR_WIDTH(8), .ISA_WIDTH(30)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .st_cur   (st_cur),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] addr, input bit flush_req, input bit flush_fill, input string name);
        logic [7:0]  off;
        logic [29:0] beats [4];
        bit          hit_exp;
        int          gap;
        off     = addr - base_m;
        hit_exp = valid_m && (off < 8'd4) && !flush_req;
        bus.ins_req  = 1'b1;
        bus.ins_addr = addr;
        bus.flush    = flush_req;
        step();
        bus.flush = 1'b0;
        if (flush_req) valid_m = 1'b0;
        if (hit_exp) begin
            checks++;
            if (bus.ins_valid !== 1'b1 || bus.ins_data !== mem_m[off[1:0]] || bus.ddr_rd_req !== 1'b0 || st_cur !== 3'd4)
                $display("FAIL %s hit: valid=%b data=%h ddr_req=%b st=%0d, expected valid=1 data=%h ddr_req=0 st=4",
                         name, bus.ins_valid, bus.ins_data, bus.ddr_rd_req, st_cur, mem_m[off[1:0]]);
            else passed++;
        end else begin
            if (miss_m != 16'hFFFF) miss_m++;
            checks++;
            if (bus.ins_valid !== 1'b0 || bus.ddr_rd_req !== 1'b1 || bus.ddr_rd_addr !== addr || st_cur !== 3'd2)
                $display("FAIL %s miss request: valid=%b ddr_req=%b addr=%h st=%0d, expected valid=0 ddr_req=1 addr=%h st=2",
                         name, bus.ins_valid, bus.ddr_rd_req, bus.ddr_rd_addr, st_cur, addr);
            else passed++;
            gap = $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) begin
                // stray beat before ack must not be stored or advance the fill
                bus.ddr_rd_data_valid = 1'b1;
                bus.ddr_rd_data       = 30'($urandom);
                step();
                bus.ddr_rd_data_valid = 1'b0;
                checks++;
                if (bus.ddr_rd_req !== 1'b1 || st_cur !== 3'd2)
                    $display("FAIL %s req hold: ddr_req=%b st=%0d, expected ddr_req=1 st=2", name, bus.ddr_rd_req, st_cur);
                else passed++;
            end
            bus.ddr_rd_ack = 1'b1;
            step();
            bus.ddr_rd_ack = 1'b0;
            checks++;
            if (bus.ddr_rd_req !== 1'b0 || st_cur !== 3'd3)
                $display("FAIL %s after ack: ddr_req=%b st=%0d, expected ddr_req=0 st=3", name, bus.ddr_rd_req, st_cur);
            else passed++;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 1) step();
                beats[i] = 30'($urandom);
                bus.ddr_rd_data_valid = 1'b1;
                bus.ddr_rd_data       = beats[i];
                bus.flush             = flush_fill && (i == 1);
                step();
                bus.ddr_rd_data_valid = 1'b0;
                bus.flush             = 1'b0;
                if (i < 3) begin
                    checks++;
                    if (bus.ins_valid !== 1'b0)
                        $display("FAIL %s early valid at beat %0d: valid=%b, expected 0", name, i, bus.ins_valid);
                    else passed++;
                end
            end
            base_m  = addr;
            mem_m   = beats;
            valid_m = !flush_fill;
            checks++;
            if (bus.ins_valid !== 1'b1 || bus.ins_data !== beats[0] || st_cur !== 3'd4)
                $display("FAIL %s fill result: valid=%b data=%h st=%0d, expected valid=1 data=%h st=4",
                         name, bus.ins_valid, bus.ins_data, st_cur, beats[0]);
            else passed++;
        end
        checks++;
        if (miss_cnt !== miss_m)
            $display("FAIL %s miss_cnt: got %0d, expected %0d", name, miss_cnt, miss_m);
        else passed++;
        bus.ins_req = 1'b0;
        step();
        checks++;
        if (bus.ins_valid !== 1'b0 || bus.ins_data !== 30'd0 || st_cur !== 3'd1)
            $display("FAIL %s return idle: valid=%b data=%h st=%0d, expected valid=0 data=0 st=1",
                     name, bus.ins_valid, bus.ins_data, st_cur);
        else passed++;
    endtask

    task automatic flush_idle();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        valid_m   = 1'b0;
        checks++;
        if (st_cur !== 3'd1 || bus.ins_valid !== 1'b0)
            $display("FAIL flush_idle: st=%0d valid=%b, expected st=1 valid=0", st_cur, bus.ins_valid);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (st_cur !== 3'd1 || bus.ins_valid !== 1'b0 || bus.ins_data !== 30'd0 ||
            bus.ddr_rd_req !== 1'b0 || bus.ddr_rd_addr !== 8'd0 || miss_cnt !== 16'd0)
            $display("FAIL reset: st=%0d valid=%b data=%h ddr_req=%b ddr_addr=%h miss=%0d, expected 1/0/0/0/0/0",
                     st_cur, bus.ins_valid, bus.ins_data, bus.ddr_rd_req, bus.ddr_rd_addr, miss_cnt);
        else passed++;
    endtask

    task automatic test_directed();
        fetch(8'h10, 1'b0, 1'b0, "cold_miss");
        fetch(8'h12, 1'b0, 1'b0, "hit");
        fetch(8'h14, 1'b0, 1'b0, "boundary_above");
        fetch(8'h13, 1'b0, 1'b0, "boundary_below");
        fetch(8'hFE, 1'b0, 1'b0, "wrap_fill");
        fetch(8'h01, 1'b0, 1'b0, "wrap_hit");
        fetch(8'h10, 1'b0, 1'b0, "refill_10");
        fetch(8'h11, 1'b1, 1'b0, "flush_with_req");
        fetch(8'h40, 1'b0, 1'b1, "flush_in_fill");
        fetch(8'h40, 1'b0, 1'b0, "after_fill_flush");
        fetch(8'h41, 1'b0, 1'b0, "hit_41");
        flush_idle();
        fetch(8'h42, 1'b0, 1'b0, "after_idle_flush");
    endtask

    task automatic test_reset_mid_fill();
        flush_idle();
        bus.ins_req  = 1'b1;
        bus.ins_addr = 8'h20;
        step();
        bus.ddr_rd_ack = 1'b1;
        step();
        bus.ddr_rd_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.ddr_rd_data_valid = 1'b1;
            bus.ddr_rd_data       = 30'($urandom);
            step();
        end
        bus.ddr_rd_data_valid = 1'b0;
        bus.ins_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (st_cur !== 3'd1 || bus.ddr_rd_req !== 1'b0 || miss_cnt !== 16'd0 || bus.ins_valid !== 1'b0)
            $display("FAIL reset_mid_fill: st=%0d ddr_req=%b miss=%0d valid=%b, expected 1/0/0/0",
                     st_cur, bus.ddr_rd_req, miss_cnt, bus.ins_valid);
        else passed++;
        valid_m = 1'b0;
        base_m  = 8'd0;
        miss_m  = 16'd0;
        fetch(8'h20, 1'b0, 1'b0, "post_reset_req");
        fetch(8'h23, 1'b0, 1'b0, "post_reset_hit");
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int n = 0; n < 40; n++) begin
            a = base_m + 8'($urandom_range(0, 7)) - 8'd2;
            if ($urandom_range(0, 9) == 0) flush_idle();
            fetch(a, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), "random");
        end
    endtask

    initial begin
        bus.ins_req           = 1'b0;
        bus.ins_addr          = 8'd0;
        bus.flush             = 1'b0;
        bus.ddr_rd_ack        = 1'b0;
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_data       = 30'd0;
        test_reset();
        test_directed();
        test_reset_mid_fill();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
